// File: rtl/dispatch_alloc_ctrl.sv
// dispatch_alloc_ctrl: per-cycle dispatch grant against freelist/ROB/RS capacity,
// plus the mispredict flush/drain sequencer for freelist recovery.
module dispatch_alloc_ctrl #(
    parameter int WAYS           = 3,
    parameter int ROB            = 5,
    parameter int CNT_W          = 6,
    parameter int RECOVER_CYCLES = 2,
    parameter int PERF_W         = 16
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic [WAYS-1:0]   dispatch_req_i,
    input  logic [WAYS-1:0]   needs_dest_i,
    input  logic [CNT_W-1:0]  fl_distance_i,
    input  logic [CNT_W-1:0]  rob_free_i,
    input  logic [CNT_W-1:0]  rs_free_i,
    input  logic              br_recover_en_i,
    input  logic [ROB-1:0]    br_recover_head_i,
    output logic [WAYS-1:0]   dispatch_grant_o,
    output logic [WAYS-1:0]   fl_dispatch_en_o,
    output logic              fl_recover_en_o,
    output logic [ROB-1:0]    fl_recover_head_o,
    output logic              stall_o,
    output logic [1:0]        state_out_o,
    output logic [PERF_W-1:0] stall_count_o
);
    localparam logic [1:0] NORMAL = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ROB-1:0]    head_q, head_d;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [WAYS-1:0]   fit;
    logic [CNT_W-1:0]  nreq, nfit, dcnt;
    logic              chain, run;

    // Every per-slot condition is a prefix condition, so fit comes out thermometer.
    always_comb begin
        chain = 1'b1;
        dcnt  = '0;
        nreq  = '0;
        nfit  = '0;
        fit   = '0;
        for (int i = 0; i < WAYS; i++) begin
            chain  = chain & dispatch_req_i[i];
            dcnt   = dcnt + CNT_W'(needs_dest_i[i]);
            fit[i] = chain && dcnt <= fl_distance_i && CNT_W'(i + 1) <= rob_free_i
                     && CNT_W'(i + 1) <= rs_free_i;
            nreq   = nreq + CNT_W'(chain);
            nfit   = nfit + CNT_W'(fit[i]);
        end
    end

    assign run              = reset_ni && state_q == NORMAL && !br_recover_en_i;
    assign dispatch_grant_o = run ? fit : '0;
    assign fl_dispatch_en_o = dispatch_grant_o & needs_dest_i;
    assign stall_o          = reset_ni && (nreq > nfit || state_q != NORMAL || br_recover_en_i);
    assign fl_recover_en_o  = state_q == FLUSH;
    assign fl_recover_head_o = head_q;
    assign state_out_o      = state_q;
    assign stall_count_o    = stall_cnt_q;

    // A new mispredict in any state restarts the sequence with the newest head.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        if (br_recover_en_i) begin
            state_d = FLUSH;
            head_d  = br_recover_head_i;
        end else if (state_q == FLUSH) begin
            state_d = DRAIN;
            cnt_d   = 4'(RECOVER_CYCLES - 1);
        end else if (state_q == DRAIN) begin
            state_d = cnt_q == 4'd0 ? NORMAL : DRAIN;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= NORMAL;
            cnt_q       <= '0;
            head_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            stall_cnt_q <= stall_cnt_q + PERF_W'(stall_o && !(&stall_cnt_q));
        end
    end
endmodule

// File: tb/tb_dispatch_alloc_ctrl.sv
// tb_dispatch_alloc_ctrl: directed and random stimulus checked against a
// cycle-offset reference model of dispatch_alloc_ctrl.
module tb_dispatch_alloc_ctrl;
    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, needs;
    logic [5:0]  fl, rob, rs;
    logic        br;
    logic [4:0]  bhead;
    logic [2:0]  grant, fl_en;
    logic        rec_en, stall;
    logic [4:0]  rec_head;
    logic [1:0]  state;
    logic [15:0] scount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tm = -100;
    int mhead = 0;
    int mstall = 0;

    dispatch_alloc_ctrl dut (
        .clock_i(clk), .reset_ni(rst_n), .dispatch_req_i(req), .needs_dest_i(needs),
        .fl_distance_i(fl), .rob_free_i(rob), .rs_free_i(rs), .br_recover_en_i(br),
        .br_recover_head_i(bhead), .dispatch_grant_o(grant), .fl_dispatch_en_o(fl_en),
        .fl_recover_en_o(rec_en), .fl_recover_head_o(rec_head), .stall_o(stall),
        .state_out_o(state), .stall_count_o(scount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] n, input int f, input int ro,
                         input int s, input logic b, input logic [4:0] h);
        req = r; needs = n; fl = 6'(f); rob = 6'(ro); rs = 6'(s); br = b; bhead = h;
    endtask

    function automatic int exp_state();
        int d = cyc - tm;
        if (d == 1) return 1;
        if (d >= 2 && d <= 1 + RC) return 2;
        return 0;
    endfunction

    // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model at the edge.
    task automatic run_cycle();
        int nreq = 0, k, dests, gcnt = 0, st, eg, es;
        while (nreq < 3 && req[nreq]) nreq++;
        for (k = nreq; k > 0; k--) begin
            dests = 0;
            for (int j = 0; j < k; j++) dests += int'(needs[j]);
            if (dests <= int'(fl) && k <= int'(rob) && k <= int'(rs)) break;
        end
        st = rst_n ? exp_state() : 0;
        eg = (rst_n && st == 0 && !br) ? (1 << k) - 1 : 0;
        for (int j = 0; j < 3; j++) gcnt += (eg >> j) & 1;
        es = rst_n && (nreq > gcnt || st != 0 || br);
        #4;
        chk("grant", int'(grant), eg);
        chk("fl_en", int'(fl_en), eg & int'(needs));
        chk("rec_en", int'(rec_en), int'(st == 1));
        chk("rec_head", int'(rec_head), rst_n ? mhead : 0);
        chk("stall", int'(stall), es);
        chk("state", int'(state), st);
        chk("scount", int'(scount), rst_n ? mstall : 0);
        @(posedge clk);
        if (rst_n) begin
            if (br) begin
                tm = cyc;
                mhead = int'(bhead);
            end
            if (es != 0 && mstall < 65535) mstall++;
        end
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        tm = -100; mhead = 0; mstall = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0);
        @(posedge clk); #1;
        // 1: reset held, then full dispatch
        run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b1, 5'd3);
        run_cycle();
        rst_n = 1'b1;
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0);
        run_cycle();
        // 2: freelist limit, destination-less instructions
        drive(3'b111, 3'b111, 2, 32, 16, 1'b0, 5'd0); run_cycle();
        drive(3'b111, 3'b010, 2, 32, 16, 1'b0, 5'd0); run_cycle();
        drive(3'b111, 3'b110, 0, 32, 16, 1'b0, 5'd0); run_cycle();
        // 3: non-contiguous request, ROB and RS limits
        drive(3'b110, 3'b111, 32, 32, 16, 1'b0, 5'd0); run_cycle();
        drive(3'b101, 3'b111, 32, 32, 16, 1'b0, 5'd0); run_cycle();
        drive(3'b111, 3'b111, 32, 1, 16, 1'b0, 5'd0); run_cycle();
        drive(3'b111, 3'b111, 32, 32, 0, 1'b0, 5'd0); run_cycle();
        // 4: mispredict and full recovery window
        drive(3'b111, 3'b111, 32, 32, 16, 1'b1, 5'd9); run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0);
        repeat (4) run_cycle();
        // 5: re-mispredict during drain, then reset pulse during flush
        drive(3'b111, 3'b111, 32, 32, 16, 1'b1, 5'd9); run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0); run_cycle();
        run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b1, 5'd4); run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0);
        repeat (5) run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b1, 5'd21); run_cycle();
        drive(3'b111, 3'b111, 32, 32, 16, 1'b0, 5'd0);
        rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_rec_en", int'(rec_en), 0);
        chk("async_head", int'(rec_head), 0);
        chk("async_scount", int'(scount), 0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); cyc++; #1;
        repeat (4) run_cycle();
        // random phase
        repeat (400) begin
            req   = 3'($urandom);
            needs = 3'($urandom);
            fl    = ($urandom % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            rob   = ($urandom % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            rs    = ($urandom % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            br    = ($urandom % 8 == 0);
            bhead = 5'($urandom);
            run_cycle();
        end
        // 6: saturation of the stall counter
        drive(3'b111, 3'b111, 32, 32, 0, 1'b0, 5'd0);
        repeat (65539) run_cycle();
        chk("scount_sat", int'(scount), 16'hFFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
